// File: rtl/chan_scan_mux_if.sv
// Bundled data/control and result signals for chan_scan_mux.
// Optional ChanMask appears when SCAN_MASK_EN is defined.
interface chan_scan_mux_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] Input;
  logic [SEL_W-1:0]          MuxSelect;
  logic                      Mode;
  logic                      Enable;
`ifdef SCAN_MASK_EN
  logic [CHANNELS-1:0]       ChanMask;
`endif
  logic [WIDTH-1:0]          Out;
  logic [SEL_W-1:0]          OutChannel;
  logic                      OutValid;
  logic                      ScanWrap;

`ifdef SCAN_MASK_EN
  modport master (output Input, MuxSelect, Mode, Enable, ChanMask,
                  input  Out, OutChannel, OutValid, ScanWrap);
  modport slave  (input  Input, MuxSelect, Mode, Enable, ChanMask,
                  output Out, OutChannel, OutValid, ScanWrap);
`else
  modport master (output Input, MuxSelect, Mode, Enable,
                  input  Out, OutChannel, OutValid, ScanWrap);
  modport slave  (input  Input, MuxSelect, Mode, Enable,
                  output Out, OutChannel, OutValid, ScanWrap);
`endif
endinterface

// File: rtl/chan_scan_mux.sv
// N-channel registered mux: select-driven manual mode or dwell-timed round-robin scan.
// Define SCAN_MASK_EN to add a per-channel ChanMask that the scan and manual paths honour.
module chan_scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 3
) (
  input  logic           Clock,
  input  logic           Reset,
  chan_scan_mux_if.slave bus
);
  localparam int SEL_W   = $clog2(CHANNELS);
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0]   LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [DWELL_W-1:0] LAST_DW = DWELL_W'(DWELL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_SAMPLE} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   out_chan_q, out_chan_d;
  logic               out_valid_q, out_valid_d;
  logic               scan_wrap_q, scan_wrap_d;

  logic [CHANNELS-1:0] mask;
  logic                sample_now;
  logic [SEL_W:0]      cur_find, nxt_find;
  logic [WIDTH:0]      man_pick, scan_pick;

  function automatic logic [SEL_W-1:0] inc_ch(input logic [SEL_W-1:0] c);
    return (c == LAST_CH) ? '0 : c + SEL_W'(1);
  endfunction

  // {found, index} of the first enabled channel at or after start, circularly.
  function automatic logic [SEL_W:0] first_set(input logic [CHANNELS-1:0] m,
                                               input logic [SEL_W-1:0]    start);
    logic             found;
    logic [SEL_W-1:0] idx, probe;
    found = 1'b0;
    idx   = start;
    probe = start;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && m[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
      probe = inc_ch(probe);
    end
    return {found, idx};
  endfunction

  // {hit, data}: hit only for an in-range, enabled channel, so unused codes read as 0.
  function automatic logic [WIDTH:0] pick(input logic [SEL_W-1:0]          sel,
                                          input logic [CHANNELS-1:0]       m,
                                          input logic [CHANNELS*WIDTH-1:0] d);
    logic [WIDTH:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i) && m[i]) r = {1'b1, d[i*WIDTH +: WIDTH]};
    end
    return r;
  endfunction

  always_comb begin
`ifdef SCAN_MASK_EN
    mask = bus.ChanMask;
`else
    mask = '1;
`endif
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    dwell_d     = dwell_q;
    out_d       = out_q;
    out_chan_d  = out_chan_q;
    out_valid_d = 1'b0;
    scan_wrap_d = 1'b0;

    sample_now = (state_q == ST_SAMPLE) || (state_q == ST_IDLE && DWELL == 1);
    cur_find   = first_set(mask, ptr_q);
    nxt_find   = first_set(mask, inc_ch(cur_find[SEL_W-1:0]));
    man_pick   = pick(bus.MuxSelect, mask, bus.Input);
    scan_pick  = pick(cur_find[SEL_W-1:0], mask, bus.Input);

    if (!bus.Mode) begin
      // Manual mode parks the sequencer so the next scan starts from channel 0.
      state_d = ST_IDLE;
      ptr_d   = '0;
      dwell_d = '0;
      if (bus.Enable) begin
        out_chan_d  = bus.MuxSelect;
        out_d       = man_pick[WIDTH-1:0];
        out_valid_d = man_pick[WIDTH];
      end
    end else if (bus.Enable) begin
      if (sample_now) begin
        dwell_d = '0;
        state_d = (DWELL == 1) ? ST_SAMPLE : ST_DWELL;
        if (cur_find[SEL_W]) begin
          out_d       = scan_pick[WIDTH-1:0];
          out_chan_d  = cur_find[SEL_W-1:0];
          out_valid_d = 1'b1;
          ptr_d       = nxt_find[SEL_W-1:0];
          scan_wrap_d = (nxt_find[SEL_W-1:0] <= cur_find[SEL_W-1:0]);
        end
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
        state_d = (dwell_q + DWELL_W'(1) == LAST_DW) ? ST_SAMPLE : ST_DWELL;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      dwell_q     <= '0;
      out_q       <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dwell_q     <= dwell_d;
      out_q       <= out_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign bus.Out        = out_q;
  assign bus.OutChannel = out_chan_q;
  assign bus.OutValid   = out_valid_q;
  assign bus.ScanWrap   = scan_wrap_q;
endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: an 8-channel/DWELL=3 and a 6-channel/DWELL=2 instance
// checked every cycle against an enabled-cycle-count reference model.
module tb_chan_scan_mux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chan_scan_mux_if #(.WIDTH(4), .CHANNELS(8)) bus8 ();
  chan_scan_mux_if #(.WIDTH(4), .CHANNELS(6)) bus6 ();

  chan_scan_mux #(.WIDTH(4), .CHANNELS(8), .DWELL(3)) u_dut8 (
    .Clock(clk), .Reset(rst), .bus(bus8));
  chan_scan_mux #(.WIDTH(4), .CHANNELS(6), .DWELL(2)) u_dut6 (
    .Clock(clk), .Reset(rst), .bus(bus6));

  typedef struct packed {
    int         n;      // enabled scan cycles since scan start, modulo one period
    logic [3:0] out;
    int         chan;
    bit         valid;
    bit         wrap;
  } model_t;

  model_t m8, m6;
  int total = 0;
  int bad   = 0;

  // Scan is defined by counting enabled cycles: every DWELL-th one samples
  // channel (n / DWELL) mod CHANNELS.
  function automatic model_t model_step(model_t m, int nch, int dw, bit r, bit mode,
                                        bit en, int sel, logic [31:0] inp);
    model_t x;
    int     c;
    x       = m;
    x.valid = 1'b0;
    x.wrap  = 1'b0;
    if (r) begin
      x = '0;
    end else if (!mode) begin
      x.n = 0;
      if (en) begin
        x.chan = sel;
        if (sel < nch) begin
          x.out   = inp[sel*4 +: 4];
          x.valid = 1'b1;
        end else begin
          x.out = 4'd0;
        end
      end
    end else if (en) begin
      if (x.n % dw == dw - 1) begin
        c       = (x.n / dw) % nch;
        x.out   = inp[c*4 +: 4];
        x.chan  = c;
        x.valid = 1'b1;
        x.wrap  = (c == nch - 1);
      end
      x.n = (x.n + 1) % (nch * dw);
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m8 = model_step(m8, 8, 3, rst, bus8.Mode, bus8.Enable, int'(bus8.MuxSelect), bus8.Input);
    m6 = model_step(m6, 6, 2, rst, bus6.Mode, bus6.Enable, int'(bus6.MuxSelect),
                    32'(bus6.Input));
    #1;
    check({tag, "/out8"},   32'(bus8.Out),        32'(m8.out));
    check({tag, "/chan8"},  32'(bus8.OutChannel), 32'(m8.chan));
    check({tag, "/valid8"}, 32'(bus8.OutValid),   32'(m8.valid));
    check({tag, "/wrap8"},  32'(bus8.ScanWrap),   32'(m8.wrap));
    check({tag, "/out6"},   32'(bus6.Out),        32'(m6.out));
    check({tag, "/chan6"},  32'(bus6.OutChannel), 32'(m6.chan));
    check({tag, "/valid6"}, 32'(bus6.OutValid),   32'(m6.valid));
    check({tag, "/wrap6"},  32'(bus6.ScanWrap),   32'(m6.wrap));
  endtask

  task automatic set_mode_en(input bit mode, input bit en);
    bus8.Mode = mode; bus8.Enable = en;
    bus6.Mode = mode; bus6.Enable = en;
  endtask

`ifdef SCAN_MASK_EN
  int seq_ch[$];
  int seq_wr[$];
  int mask_valids;
`endif

  initial begin
    m8 = '0;
    m6 = '0;
    rst = 1'b1;
    set_mode_en(1'b1, 1'b1);
    bus8.Input = 32'h8765_4321;
    bus6.Input = 24'h65_4321;
    bus8.MuxSelect = '0;
    bus6.MuxSelect = '0;
`ifdef SCAN_MASK_EN
    bus8.ChanMask = '1;
    bus6.ChanMask = '1;
`endif

    // Reset held with scan requested.
    tick("reset0");
    tick("reset1");
    check("reset_out8", 32'(bus8.Out), 32'd0);

    // Manual select; channel 7 is an unused code on the 6-channel instance.
    rst = 1'b0;
    set_mode_en(1'b0, 1'b1);
    bus8.MuxSelect = 3'd5;
    bus6.MuxSelect = 3'd7;
    tick("manual5");
    check("man5_out8",   32'(bus8.Out),      32'd6);
    check("man5_valid8", 32'(bus8.OutValid), 32'd1);
    check("oor_out6",    32'(bus6.Out),      32'd0);
    check("oor_valid6",  32'(bus6.OutValid), 32'd0);
    bus8.MuxSelect = 3'd2;
    tick("manual2");
    check("man2_out8", 32'(bus8.Out), 32'd3);

    // Scan from a clean start: samples every 3rd enabled cycle, wrap on channel 7.
    set_mode_en(1'b1, 1'b1);
    for (int i = 1; i <= 27; i++) begin
      tick("scan");
      if (i == 24) begin
        check("scan24_out8",  32'(bus8.Out),      32'd8);
        check("scan24_wrap8", 32'(bus8.ScanWrap), 32'd1);
      end
      if (i == 27) begin
        check("scan27_out8",   32'(bus8.Out),      32'd1);
        check("scan27_valid8", 32'(bus8.OutValid), 32'd1);
        check("scan27_wrap8",  32'(bus8.ScanWrap), 32'd0);
      end
    end

    // Hold at dwell=1 for 5 cycles; the channel-1 sample lands 5 cycles late.
    tick("pre_hold");
    set_mode_en(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick("hold");
    check("hold_out8", 32'(bus8.Out), 32'd1);
    set_mode_en(1'b1, 1'b1);
    tick("resume0");
    check("resume0_valid8", 32'(bus8.OutValid), 32'd0);
    tick("resume1");
    check("resume1_out8",  32'(bus8.Out),        32'd2);
    check("resume1_chan8", 32'(bus8.OutChannel), 32'd1);

    // Drop to manual with select 7.
    set_mode_en(1'b0, 1'b1);
    bus8.MuxSelect = 3'd7;
    tick("switch");
    check("switch_out8", 32'(bus8.Out), 32'd8);

    // Reset mid-scan once the 6-channel pointer has reached 4, then restart.
    set_mode_en(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick("prescan");
    rst = 1'b1;
    tick("midreset");
    check("midreset_valid6", 32'(bus6.OutValid), 32'd0);
    rst = 1'b0;
    tick("restart0");
    tick("restart1");
    check("restart_valid6", 32'(bus6.OutValid),   32'd1);
    check("restart_chan6",  32'(bus6.OutChannel), 32'd0);

    // Randomised traffic: data every cycle, occasional mode flips, gaps and resets.
    for (int i = 0; i < 400; i++) begin
      bus8.Input = $urandom;
      bus6.Input = 24'($urandom);
      bus8.MuxSelect = 3'($urandom_range(0, 7));
      bus6.MuxSelect = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) set_mode_en(~bus8.Mode, bus8.Enable);
      bus8.Enable = ($urandom_range(0, 4) != 0);
      bus6.Enable = bus8.Enable;
      rst = ($urandom_range(0, 40) == 0);
      tick("rand");
    end
    rst = 1'b0;

`ifdef SCAN_MASK_EN
    // Masked scan: channels 2, 5, 7 only; wrap accompanies channel 7.
    rst = 1'b1;
    bus8.Input = 32'h8765_4321;
    bus8.ChanMask = 8'b1010_0100;
    set_mode_en(1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (bus8.OutValid) begin
        seq_ch.push_back(int'(bus8.OutChannel));
        seq_wr.push_back(int'(bus8.ScanWrap));
      end
    end
    check("mask_count", 32'(seq_ch.size()), 32'd4);
    if (seq_ch.size() >= 4) begin
      check("mask_ch0", 32'(seq_ch[0]), 32'd2);
      check("mask_ch1", 32'(seq_ch[1]), 32'd5);
      check("mask_ch2", 32'(seq_ch[2]), 32'd7);
      check("mask_ch3", 32'(seq_ch[3]), 32'd2);
      check("mask_wr1", 32'(seq_wr[1]), 32'd0);
      check("mask_wr2", 32'(seq_wr[2]), 32'd1);
    end
    bus8.ChanMask = '0;
    mask_valids = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus8.OutValid) mask_valids++;
    end
    check("mask_zero_valids", 32'(mask_valids), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
